// File: rtl/pwm_pkg.sv
// pwm_pkg: constants and types shared by the servo PWM generator and capture
package pwm_pkg;

    localparam int CW = 21;

    // Generator high times for 1.0 / 1.5 / 2.0 ms at 100 MHz
    localparam logic [CW-1:0] PW_LEFT    = 21'h186A0;
    localparam logic [CW-1:0] PW_NEUTRAL = 21'h249F0;
    localparam logic [CW-1:0] PW_RIGHT   = 21'h30D40;

    localparam logic [CW-1:0] TH_LN   = 21'h1BBA6;
    localparam logic [CW-1:0] TH_NR   = 21'h25FEF;
    localparam logic [CW-1:0] TIMEOUT = 21'h1FFFFF;

    typedef enum logic [1:0] {SYNC, HIGH, LOW, DEAD} state_t;

    localparam logic [2:0] POS_LEFT    = 3'b100;
    localparam logic [2:0] POS_NEUTRAL = 3'b010;
    localparam logic [2:0] POS_RIGHT   = 3'b001;
    localparam logic [2:0] POS_NONE    = 3'b000;

    localparam logic [1:0] STUCK_NONE = 2'b00;
    localparam logic [1:0] STUCK_LO   = 2'b01;
    localparam logic [1:0] STUCK_HI   = 2'b10;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-FF synchronizer with a registered copy for edge detection
// Ports: clk; din async input; level synchronized input; rise/fall one-cycle edge strobes.
module sync_edge_detect (
    input  logic clk,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta_d, meta_q, sync_d, sync_q, prev_d, prev_q;

    // No reset: the chain keeps tracking the pin during reset, so a pin that is
    // already high at release does not look like a fresh rising edge.
    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        meta_q <= meta_d;
        sync_q <= sync_d;
        prev_q <= prev_d;
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures servo PWM high time and period, decodes position, flags stuck input
// Ports: CLK, RESET (sync, active-high), PWM_IN async input;
//        HIGH_COUNT / PERIOD_COUNT last measurement, POS one-hot position,
//        VALID one-cycle load strobe, STUCK 00 ok / 01 stuck low / 10 stuck high.
module pwm_capture #(
    parameter int              CW      = pwm_pkg::CW,
    parameter logic [CW-1:0]   TIMEOUT = pwm_pkg::TIMEOUT,
    parameter logic [CW-1:0]   TH_LN   = pwm_pkg::TH_LN,
    parameter logic [CW-1:0]   TH_NR   = pwm_pkg::TH_NR
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          PWM_IN,
    output logic [CW-1:0] HIGH_COUNT,
    output logic [CW-1:0] PERIOD_COUNT,
    output logic [2:0]    POS,
    output logic          VALID,
    output logic [1:0]    STUCK
);
    import pwm_pkg::*;

    state_t        state_q, state_d;
    logic [CW-1:0] hcnt_q, hcnt_d, pcnt_q, pcnt_d;
    logic [CW-1:0] high_q, high_d, period_q, period_d;
    logic [2:0]    pos_q, pos_d;
    logic          valid_q, valid_d;
    logic [1:0]    stuck_q, stuck_d;
    logic          level, rise, fall, stuck_hi;
    logic [CW-1:0] h_inc, p_inc;
    logic [2:0]    pos_cap;

    sync_edge_detect u_sync (
        .clk  (CLK),
        .din  (PWM_IN),
        .level(level),
        .rise (rise),
        .fall (fall)
    );

    assign h_inc    = (hcnt_q == TIMEOUT) ? hcnt_q : hcnt_q + CW'(1);
    assign p_inc    = (pcnt_q == TIMEOUT) ? pcnt_q : pcnt_q + CW'(1);
    assign pos_cap  = (hcnt_q == '0) ? POS_NONE :
                      (hcnt_q < TH_LN) ? POS_LEFT :
                      (hcnt_q < TH_NR) ? POS_NEUTRAL : POS_RIGHT;
    assign stuck_hi = (state_q == HIGH) || (state_q == SYNC && level);

    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        pcnt_d   = pcnt_q;
        high_d   = high_q;
        period_d = period_q;
        pos_d    = pos_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;
        if (rise) begin
            // The rise cycle is the first cycle of the new period.
            state_d = HIGH;
            hcnt_d  = CW'(1);
            pcnt_d  = CW'(1);
            stuck_d = (state_q == DEAD) ? STUCK_NONE : stuck_q;
            if (state_q == LOW) begin
                high_d   = hcnt_q;
                period_d = pcnt_q;
                pos_d    = pos_cap;
                valid_d  = 1'b1;
            end
        end else if (state_q != DEAD && pcnt_q == TIMEOUT) begin
            state_d  = DEAD;
            stuck_d  = stuck_hi ? STUCK_HI : STUCK_LO;
            high_d   = stuck_hi ? TIMEOUT : '0;
            period_d = TIMEOUT;
            pos_d    = POS_NONE;
            valid_d  = 1'b1;
        end else begin
            case (state_q)
                SYNC: pcnt_d = fall ? '0 : p_inc;
                HIGH: begin
                    pcnt_d  = p_inc;
                    hcnt_d  = fall ? hcnt_q : h_inc;
                    state_d = fall ? LOW : HIGH;
                end
                LOW:  pcnt_d = p_inc;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= SYNC;
            hcnt_q   <= '0;
            pcnt_q   <= '0;
            high_q   <= '0;
            period_q <= '0;
            pos_q    <= POS_NONE;
            valid_q  <= 1'b0;
            stuck_q  <= STUCK_NONE;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            pcnt_q   <= pcnt_d;
            high_q   <= high_d;
            period_q <= period_d;
            pos_q    <= pos_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
        end
    end

    assign HIGH_COUNT   = high_q;
    assign PERIOD_COUNT = period_q;
    assign POS          = pos_q;
    assign VALID        = valid_q;
    assign STUCK        = stuck_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture with scaled-down timing parameters
module tb_pwm_capture;
    localparam int CW = 21;
    localparam int T  = 3000;
    localparam int LN = 300;
    localparam int NR = 500;

    typedef struct packed {
        logic [CW-1:0] h;
        logic [CW-1:0] p;
        logic [2:0]    pos;
        logic [1:0]    st;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pwm = 1'b0;
    logic [CW-1:0] high_count, period_count;
    logic [2:0]    pos;
    logic          valid;
    logic [1:0]    stuck;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pwm_capture #(
        .CW     (CW),
        .TIMEOUT(CW'(T)),
        .TH_LN  (CW'(LN)),
        .TH_NR  (CW'(NR))
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .PWM_IN      (pwm),
        .HIGH_COUNT  (high_count),
        .PERIOD_COUNT(period_count),
        .POS         (pos),
        .VALID       (valid),
        .STUCK       (stuck)
    );

    function automatic exp_t meas(input int h, input int p);
        exp_t e;
        e.h   = CW'(h);
        e.p   = CW'(p);
        e.pos = (h == 0) ? 3'b000 : (h < LN) ? 3'b100 : (h < NR) ? 3'b010 : 3'b001;
        e.st  = 2'b00;
        return e;
    endfunction

    function automatic exp_t stuck_exp(input logic hi);
        exp_t e;
        e.h   = hi ? CW'(T) : '0;
        e.p   = CW'(T);
        e.pos = 3'b000;
        e.st  = hi ? 2'b10 : 2'b01;
        return e;
    endfunction

    // One clock of stimulus; any VALID seen is matched against the scoreboard head.
    task automatic tick(input logic lvl);
        exp_t e, g;
        @(posedge clk);
        #1 pwm = lvl;
        @(negedge clk);
        if (valid) begin
            n_cmp++;
            g = {high_count, period_count, pos, stuck};
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_valid: got h=%0d p=%0d pos=%b stuck=%b, wanted no VALID",
                         high_count, period_count, pos, stuck);
            end else begin
                e = sb.pop_front();
                if (g !== e) begin
                    n_err++;
                    $display("FAIL sb_measure: got h=%0d p=%0d pos=%b stuck=%b, wanted h=%0d p=%0d pos=%b stuck=%b",
                             high_count, period_count, pos, stuck, e.h, e.p, e.pos, e.st);
                end
            end
        end
    endtask

    task automatic period(input int h, input int p, input bit push);
        repeat (h) tick(1'b1);
        repeat (p - h) tick(1'b0);
        if (push) sb.push_back(meas(h, p));
    endtask

    task automatic drain(input logic lvl, input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) tick(lvl);
        repeat (5) tick(lvl);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d outstanding reports, wanted 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset(input logic lvl);
        rst = 1'b1;
        repeat (4) tick(lvl);
        rst = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        n_cmp++;
        if ({high_count, period_count, pos, valid, stuck} !== '0) begin
            n_err++;
            $display("FAIL %s: got h=%0d p=%0d pos=%b valid=%b stuck=%b, wanted all zero",
                     tag, high_count, period_count, pos, valid, stuck);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) tick(1'b0);
        n_cmp++;
        if (high_count !== '0) begin n_err++; $display("FAIL reset_high: got %0d wanted 0", high_count); end
        n_cmp++;
        if (period_count !== '0) begin n_err++; $display("FAIL reset_period: got %0d wanted 0", period_count); end
        n_cmp++;
        if (pos !== 3'b000) begin n_err++; $display("FAIL reset_pos: got %b wanted 000", pos); end
        n_cmp++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b wanted 0", valid); end
        n_cmp++;
        if (stuck !== 2'b00) begin n_err++; $display("FAIL reset_stuck: got %b wanted 00", stuck); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset(1'b0);
        repeat (3) period(40, 100, 1'b1);
        tick(1'b1);
        drain(1'b1, 20);
    endtask

    task automatic test_long_period();
        do_reset(1'b0);
        period(400, T, 1'b1);
        period(600, T, 1'b1);
        tick(1'b1);
        drain(1'b1, 20);
    endtask

    task automatic test_thresholds();
        do_reset(1'b0);
        period(LN - 1, 1000, 1'b1);
        period(LN, 1000, 1'b1);
        period(NR - 1, 1000, 1'b1);
        period(NR, 1000, 1'b1);
        tick(1'b1);
        drain(1'b1, 20);
    endtask

    task automatic test_stuck();
        do_reset(1'b0);
        period(40, 100, 1'b1);
        repeat (40) tick(1'b1);
        sb.push_back(stuck_exp(1'b0));
        drain(1'b0, T + 200);
        n_cmp++;
        if (stuck !== 2'b01) begin n_err++; $display("FAIL stuck_low_flag: got %b wanted 01", stuck); end
        repeat (5) tick(1'b1);
        n_cmp++;
        if (stuck !== 2'b00) begin n_err++; $display("FAIL stuck_low_clear: got %b wanted 00", stuck); end
        n_cmp++;
        if (high_count !== '0) begin n_err++; $display("FAIL stuck_hold: got h=%0d wanted 0", high_count); end
        sb.push_back(stuck_exp(1'b1));
        drain(1'b1, T + 200);
        n_cmp++;
        if (stuck !== 2'b10) begin n_err++; $display("FAIL stuck_high_flag: got %b wanted 10", stuck); end
        repeat (10) tick(1'b0);
        repeat (5) tick(1'b1);
        n_cmp++;
        if (stuck !== 2'b00) begin n_err++; $display("FAIL stuck_high_clear: got %b wanted 00", stuck); end
        drain(1'b1, 20);
    endtask

    task automatic test_reset_mid_high();
        do_reset(1'b0);
        period(40, 100, 1'b1);
        repeat (20) tick(1'b1);
        rst = 1'b1;
        tick(1'b1);
        check_zero_outputs("reset_mid_high");
        rst = 1'b0;
        repeat (20) tick(1'b1);
        repeat (60) tick(1'b0);
        period(70, 100, 1'b1);
        tick(1'b1);
        drain(1'b1, 20);
    endtask

    task automatic test_start_high();
        do_reset(1'b1);
        repeat (30) tick(1'b1);
        repeat (50) tick(1'b0);
        period(60, 100, 1'b1);
        tick(1'b1);
        drain(1'b1, 20);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long_period();
        test_thresholds();
        test_stuck();
        test_reset_mid_high();
        test_start_high();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
